acc_drain_buffer: RTL and testbench

//  Downstream of the per-column accumulation collectors at the bottom of the systolic array.

---
 rtl/vmx_pkg.sv | 21 ++
 rtl/acc_row_buffer.sv | 36 +++
 rtl/acc_drain_buffer.sv | 146 ++++++++++++++
 tb/tb_acc_drain_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vmx_pkg.sv
// Shared types and helpers for the vector/matrix accumulation datapath.
// Provides default widths, the drain FSM state type and clog2.
package vmx_pkg;

    localparam int VMX_DATA_W = 32;
    localparam int VMX_N_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } drain_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/acc_row_buffer.sv
// Row storage for the drain buffer: one independent write port per column
// and a single combinational read port returning a whole row.
module acc_row_buffer
    import vmx_pkg::*;
#(
    parameter int N_COLS = VMX_N_COLS,
    parameter int DATA_W = VMX_DATA_W,
    parameter int DEPTH  = 8,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic [N_COLS-1:0]        wr_en,
    input  logic [N_COLS*AW-1:0]     wr_addr,
    input  logic [N_COLS*DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [N_COLS*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH][N_COLS];

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_COLS; c++) begin
            if (wr_en[c]) begin
                mem[wr_addr[c*AW +: AW]][c] <= wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < N_COLS; c++) begin
            rd_data[c*DATA_W +: DATA_W] = mem[rd_addr][c];
        end
    end

endmodule

// File: rtl/acc_drain_buffer.sv
// Deskews diagonally staggered column sums into rows and streams them out.
// Optional ReLU on read is enabled by defining ACC_DRAIN_RELU_EN.
module acc_drain_buffer
    import vmx_pkg::*;
#(
    parameter int N_COLS = VMX_N_COLS,
    parameter int DATA_W = VMX_DATA_W,
    parameter int DEPTH  = 8,
    parameter int ROW_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W-1:0]         num_rows,
    input  logic [N_COLS-1:0]        col_en,
    input  logic [N_COLS*DATA_W-1:0] col_sum,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_COLS*DATA_W-1:0] out_data,
    output logic                     done,
    output logic                     err
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    drain_state_t state, state_nx;

    logic [PW-1:0]           wp [N_COLS];
    logic [PW-1:0]           rp;
    logic [ROW_W-1:0]        rows_issued;
    logic [ROW_W-1:0]        rows_out;
    logic [ROW_W-1:0]        num_rows_q;
    logic [PW-1:0]           fill0;
    logic [PW-1:0]           occ;
    logic                    active;
    logic                    full0;
    logic                    hs;
    logic                    last_hs;
    logic [N_COLS-1:0]       wr_en;
    logic [N_COLS*AW-1:0]    wr_addr;
    logic [N_COLS*DATA_W-1:0] row_raw;

    assign active    = (state == ACTIVE);
    assign fill0     = wp[0] - rp;
    assign occ       = wp[N_COLS-1] - rp;
    assign full0     = (fill0 == PW'(DEPTH));
    assign in_ready  = active && (fill0 < PW'(DEPTH))
                       && (rows_issued < num_rows_q);
    assign out_valid = active && (occ != '0);
    assign hs        = out_valid && out_ready;
    assign last_hs   = hs && (rows_out == num_rows_q - ROW_W'(1));
    assign done      = (state == DONE);

    // Column 0 owns the write budget; later columns trail it by the skew.
    always_comb begin
        wr_en   = col_en & {N_COLS{active}};
        wr_en[0] = wr_en[0] & ~full0;
        wr_addr = '0;
        for (int c = 0; c < N_COLS; c++) begin
            wr_addr[c*AW +: AW] = wp[c][AW-1:0];
        end
    end

    acc_row_buffer #(
        .N_COLS (N_COLS),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (col_sum),
        .rd_addr (rp[AW-1:0]),
        .rd_data (row_raw)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (num_rows == '0) ? DONE : ACTIVE;
            end
            ACTIVE: begin
                if (last_hs) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rp          <= '0;
            rows_issued <= '0;
            rows_out    <= '0;
            num_rows_q  <= '0;
            err         <= 1'b0;
            for (int c = 0; c < N_COLS; c++) wp[c] <= '0;
        end else begin
            state <= state_nx;
            for (int c = 0; c < N_COLS; c++) begin
                if (wr_en[c]) wp[c] <= wp[c] + PW'(1);
            end
            if (wr_en[0]) rows_issued <= rows_issued + ROW_W'(1);
            if (hs) begin
                rp       <= rp + PW'(1);
                rows_out <= rows_out + ROW_W'(1);
            end
            // Leaving DONE: clear pointers so the next tile starts at slot 0.
            if (state == DONE) begin
                rp          <= '0;
                rows_issued <= '0;
                rows_out    <= '0;
                for (int c = 0; c < N_COLS; c++) wp[c] <= '0;
            end
            if (state == IDLE && start) begin
                num_rows_q <= num_rows;
                err        <= 1'b0;
            end else if ((|col_en && !active) || (active && col_en[0] && full0)) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        logic [DATA_W-1:0] f;
        out_data = '0;
        f = '0;
        if (out_valid) begin
            for (int c = 0; c < N_COLS; c++) begin
                f = row_raw[c*DATA_W +: DATA_W];
`ifdef ACC_DRAIN_RELU_EN
                if (f[DATA_W-1]) f = '0;
`else
                f = f;
`endif
                out_data[c*DATA_W +: DATA_W] = f;
            end
        end
    end

endmodule

// File: tb/tb_acc_drain_buffer.sv
// Directed scoreboard bench for acc_drain_buffer (skewed writes, drain, err, rst).
// Expected rows honour ACC_DRAIN_RELU_EN when it is defined.
module tb_acc_drain_buffer;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int RW    = 8;
    localparam int RWID  = N * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [RW-1:0]   num_rows;
    logic [N-1:0]    col_en;
    logic [RWID-1:0] col_sum;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [RWID-1:0] out_data;
    logic            done;
    logic            err;

    int tests = 0;
    int fails = 0;
    int popped = 0;
    logic [RWID-1:0] sb [$];
    logic [RWID-1:0] tile_rows [64];
    logic [RWID-1:0] exp6;

    always #5 clk = ~clk;

    acc_drain_buffer #(
        .N_COLS (N),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ROW_W  (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .col_en    (col_en),
        .col_sum   (col_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done),
        .err       (err)
    );

    function automatic logic [RWID-1:0] model(input logic [RWID-1:0] r);
        logic [RWID-1:0] m;
        m = r;
`ifdef ACC_DRAIN_RELU_EN
        for (int c = 0; c < N; c++) begin
            if (r[c*DW + DW - 1]) m[c*DW +: DW] = '0;
        end
`endif
        return m;
    endfunction

    task automatic chk(input string tag, input logic [RWID-1:0] got,
                       input logic [RWID-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            popped++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL extra_row observed=%h expected=none", out_data);
            end else begin
                chk("row", out_data, sb.pop_front());
            end
        end
    end

    task automatic finish_checks();
        chk("done_pulse", done, 1);
        chk("no_valid_in_done", out_valid, 0);
        @(posedge clk); #1;
        chk("done_low", done, 0);
        chk("in_ready_idle", in_ready, 0);
    endtask

    // mode 0: ready=1, 1: ready toggles, 2: ready=0 and stop after writes,
    // 3: ready=1 and stop once two rows have been issued.
    task automatic tile(input int n, input int mode);
        int  issue_cyc [64];
        int  issued;
        bit  fin;
        bit  ok;
        issued = 0;
        ok = 0;
        popped = 0;
        start = 1'b1;
        num_rows = RW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_clr_on_start", err, 0);
        out_ready = (mode == 0 || mode == 3);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            col_en = '0;
            col_sum = '0;
            fin = (issued == n) && (cyc > issue_cyc[n-1] + N - 1);
            if (mode == 3 && issued == 2) begin ok = 1; break; end
            if (mode == 2 && fin) begin ok = 1; break; end
            if (mode < 2 && fin && sb.size() == 0) begin ok = 1; break; end
            chk("in_ready", in_ready,
                1'((issued < n) && ((issued - popped) < DEPTH)));
            if (mode == 1) out_ready = ~out_ready;
            if (issued < n && in_ready) begin
                issue_cyc[issued] = cyc;
                sb.push_back(model(tile_rows[issued]));
                issued++;
            end
            for (int c = 0; c < N; c++) begin
                for (int k = 0; k < issued; k++) begin
                    if (issue_cyc[k] + c == cyc) begin
                        col_en[c] = 1'b1;
                        col_sum[c*DW +: DW] = tile_rows[k][c*DW +: DW];
                    end
                end
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $error("FAIL tile_timeout observed=stuck expected=complete n=%0d", n);
        end
        if (mode < 2 && ok) finish_checks();
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            if (sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            tests++;
            fails++;
            $error("FAIL drain_timeout observed=%0d expected=0 rows left", sb.size());
        end else begin
            finish_checks();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_rows = '0;
        col_en = '0;
        col_sum = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++)
            for (int c = 0; c < N; c++)
                tile_rows[k][c*DW +: DW] = DW'(k * N + c + 1);
        tile(3, 0);

        for (int k = 0; k < 8; k++)
            for (int c = 0; c < N; c++)
                tile_rows[k][c*DW +: DW] = 32'h0A00_0000 + DW'(k * 16 + c);
        tile(8, 2);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_hold_data", out_data, sb[0]);
        col_en = 4'b0001;
        col_sum = '1;
        @(posedge clk); #1;
        col_en = '0;
        col_sum = '0;
        chk("overflow_err", err, 1);
        chk("overflow_data", out_data, sb[0]);
        chk("overflow_in_ready", in_ready, 0);
        drain();

        for (int k = 0; k < 20; k++)
            for (int c = 0; c < N; c++)
                tile_rows[k][c*DW +: DW] = $urandom;
        tile(20, 1);

        start = 1'b1;
        num_rows = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_no_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("zero_done_low", done, 0);
        col_en = 4'b0100;
        @(posedge clk); #1;
        col_en = '0;
        chk("idle_write_err", err, 1);
        @(posedge clk); #1;
        chk("err_sticky", err, 1);
        tile_rows[0] = {32'd44, 32'd33, 32'd22, 32'd11};
        tile(1, 0);

        for (int k = 0; k < 5; k++)
            for (int c = 0; c < N; c++)
                tile_rows[k][c*DW +: DW] = DW'(100 + k * N + c);
        tile(5, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_out_data", out_data, 0);
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("midrst_no_done", done, 0);
        tile(5, 0);

        tile_rows[0] = {32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};
`ifdef ACC_DRAIN_RELU_EN
        exp6 = {32'd3, 32'd0, 32'd7, 32'd0};
`else
        exp6 = {32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};
`endif
        tile(1, 2);
        chk("relu_row", out_data, exp6);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
